// File: rtl/elevator_scheduler.sv
// SCAN-policy car scheduler: chooses direction, times travel and door, clears served requests.
// Define ELEV_IDLE_HOME_EN to build the idle-homing trip back to level 0.
module elevator_scheduler #(
  parameter int unsigned LEVELS        = 8,
  parameter int unsigned LEVEL_W       = $clog2(LEVELS),
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3,
  parameter int unsigned HOME_DELAY    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVELS-1:0]  active_in_levels,
  input  logic [LEVELS-1:0]  active_out_up_levels,
  input  logic [LEVELS-1:0]  active_out_down_levels,
  output logic [LEVELS-1:0]  inactivate_in_levels,
  output logic [LEVELS-1:0]  inactivate_out_up_levels,
  output logic [LEVELS-1:0]  inactivate_out_down_levels,
  output logic [LEVEL_W-1:0] current_level,
  output logic               direction,
  output logic               moving,
  output logic               door_open
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MOVE   = 2'd1;
  localparam logic [1:0] ST_ARRIVE = 2'd2;
  localparam logic [1:0] ST_OPEN   = 2'd3;

  localparam int unsigned TMAX    = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TIMER_W = $clog2(TMAX + 1);
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] TOP_LEVEL   = LEVEL_W'(LEVELS - 1);

  logic [1:0]         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               dir_q, dir_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [LEVELS-1:0]  clr_in_q, clr_in_d;
  logic [LEVELS-1:0]  clr_up_q, clr_up_d;
  logic [LEVELS-1:0]  clr_dn_q, clr_dn_d;
  logic               moving_q, moving_d;
  logic               door_q, door_d;

  logic [LEVELS-1:0]  req;
  logic               above, below, here;
  logic               in_here, up_here, dn_here, hall_fwd;
  logic               stop_here, opp_only, ahead;
  logic               new_in, new_hall;
  logic               enter_open, open_dir;

`ifdef ELEV_IDLE_HOME_EN
  localparam int unsigned HOME_W = $clog2(HOME_DELAY + 1);
  logic [HOME_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic               home_q, home_d;
`else
  // HOME_DELAY only matters when homing is built
  if (HOME_DELAY == 0) begin : g_home_unused
  end
`endif

  // Request summary relative to the car position
  always_comb begin : req_scan
    req   = active_in_levels | active_out_up_levels | active_out_down_levels;
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < LEVELS; i++) begin
      if (LEVEL_W'(i) > level_q) above = above | req[i];
      if (LEVEL_W'(i) < level_q) below = below | req[i];
    end
    here      = req[level_q];
    in_here   = active_in_levels[level_q];
    up_here   = active_out_up_levels[level_q];
    dn_here   = active_out_down_levels[level_q];
    hall_fwd  = dir_q ? up_here : dn_here;
    stop_here = dir_q ? (in_here | up_here | (dn_here & ~above))
                      : (in_here | dn_here | (up_here & ~below));
    opp_only  = ~(in_here | hall_fwd);
    ahead     = dir_q ? above : below;
    // a bit pulsed last cycle is still visible until the latch clears it
    new_in    = in_here & ~clr_in_q[level_q];
    new_hall  = dir_q ? (up_here & ~clr_up_q[level_q]) : (dn_here & ~clr_dn_q[level_q]);
  end

  always_comb begin : next_state
    state_d    = state_q;
    level_d    = level_q;
    dir_d      = dir_q;
    timer_d    = timer_q;
    clr_in_d   = '0;
    clr_up_d   = '0;
    clr_dn_d   = '0;
    enter_open = 1'b0;
    open_dir   = dir_q;
`ifdef ELEV_IDLE_HOME_EN
    home_d     = home_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (here) begin
          enter_open = 1'b1;
          open_dir   = opp_only ? ~dir_q : dir_q;
        end else if (above || below) begin
          state_d = ST_MOVE;
          timer_d = TRAVEL_LOAD;
          if (above && !below)      dir_d = 1'b1;
          else if (below && !above) dir_d = 1'b0;
        end
`ifdef ELEV_IDLE_HOME_EN
        else if ((level_q != '0) && (idle_cnt_q == HOME_W'(HOME_DELAY - 1))) begin
          state_d = ST_MOVE;
          timer_d = TRAVEL_LOAD;
          dir_d   = 1'b0;
          home_d  = 1'b1;
        end
`endif
      end
      ST_MOVE: begin
        if (timer_q == '0) begin
          state_d = ST_ARRIVE;
          if (dir_q && (level_q != TOP_LEVEL))     level_d = level_q + LEVEL_W'(1);
          else if (!dir_q && (level_q != '0))      level_d = level_q - LEVEL_W'(1);
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_ARRIVE: begin
        if (stop_here) begin
          enter_open = 1'b1;
          open_dir   = opp_only ? ~dir_q : dir_q;
        end else if (ahead) begin
          state_d = ST_MOVE;
          timer_d = TRAVEL_LOAD;
        end
`ifdef ELEV_IDLE_HOME_EN
        else if (home_q && (req == '0) && (level_q != '0)) begin
          state_d = ST_MOVE;
          timer_d = TRAVEL_LOAD;
        end
`endif
        else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (new_in || new_hall) begin
          timer_d           = DOOR_LOAD;
          clr_in_d[level_q] = new_in;
          clr_up_d[level_q] = new_hall & dir_q;
          clr_dn_d[level_q] = new_hall & ~dir_q;
        end else if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
    endcase

    if (enter_open) begin
      state_d           = ST_OPEN;
      timer_d           = DOOR_LOAD;
      dir_d             = open_dir;
      clr_in_d[level_q] = in_here;
      clr_up_d[level_q] = up_here & open_dir;
      clr_dn_d[level_q] = dn_here & ~open_dir;
    end

`ifdef ELEV_IDLE_HOME_EN
    if (((state_q == ST_ARRIVE) && (req != '0)) ||
        ((state_d != ST_MOVE) && (state_d != ST_ARRIVE))) home_d = 1'b0;
    idle_cnt_d = ((state_q == ST_IDLE) && (state_d == ST_IDLE) && (req == '0) && (level_q != '0))
                 ? idle_cnt_q + HOME_W'(1) : '0;
`endif

    moving_d = (state_d == ST_MOVE);
    door_d   = (state_d == ST_OPEN);
  end

  always_ff @(posedge clk or negedge reset) begin : regs
    if (!reset) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      dir_q    <= 1'b1;
      timer_q  <= '0;
      clr_in_q <= '0;
      clr_up_q <= '0;
      clr_dn_q <= '0;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      clr_in_q <= clr_in_d;
      clr_up_q <= clr_up_d;
      clr_dn_q <= clr_dn_d;
      moving_q <= moving_d;
      door_q   <= door_d;
    end
  end

`ifdef ELEV_IDLE_HOME_EN
  always_ff @(posedge clk or negedge reset) begin : home_regs
    if (!reset) begin
      idle_cnt_q <= '0;
      home_q     <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      home_q     <= home_d;
    end
  end
`endif

  assign inactivate_in_levels       = clr_in_q;
  assign inactivate_out_up_levels   = clr_up_q;
  assign inactivate_out_down_levels = clr_dn_q;
  assign current_level              = level_q;
  assign direction                  = dir_q;
  assign moving                     = moving_q;
  assign door_open                  = door_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with a request-latch model and a clear-pulse scoreboard.
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] act_in = 8'h00, act_up = 8'h00, act_dn = 8'h00;
  logic [7:0] inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels;
  logic [2:0] current_level;
  logic       direction, moving, door_open;

  typedef struct packed {
    logic [7:0] in_m;
    logic [7:0] up_m;
    logic [7:0] dn_m;
    logic [2:0] lvl;
  } exp_t;

  exp_t       sb[$];
  int         n_pass = 0, n_fail = 0, n_total = 0;
  logic [7:0] pend_in = 8'h00, pend_up = 8'h00, pend_dn = 8'h00;

  always #5 clk = ~clk;

  elevator_scheduler #(
    .LEVELS(8), .LEVEL_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3), .HOME_DELAY(10)
  ) dut (
    .clk                        (clk),
    .reset                      (rst_n),
    .active_in_levels           (act_in),
    .active_out_up_levels       (act_up),
    .active_out_down_levels     (act_dn),
    .inactivate_in_levels       (inactivate_in_levels),
    .inactivate_out_up_levels   (inactivate_out_up_levels),
    .inactivate_out_down_levels (inactivate_out_down_levels),
    .current_level              (current_level),
    .direction                  (direction),
    .moving                     (moving),
    .door_open                  (door_open)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] i, input logic [7:0] u, input logic [7:0] d,
                          input logic [2:0] l);
    exp_t e;
    e.in_m = i; e.up_m = u; e.dn_m = d; e.lvl = l;
    sb.push_back(e);
  endtask

  // One clock: latch model applies last cycle's clears, then any pulse is scored.
  task automatic step();
    exp_t o, e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      act_in = 8'h00; act_up = 8'h00; act_dn = 8'h00;
    end else begin
      act_in = act_in & ~pend_in;
      act_up = act_up & ~pend_up;
      act_dn = act_dn & ~pend_dn;
    end
    pend_in = inactivate_in_levels;
    pend_up = inactivate_out_up_levels;
    pend_dn = inactivate_out_down_levels;
    if ((pend_in | pend_up | pend_dn) != 8'h00) begin
      o.in_m = pend_in; o.up_m = pend_up; o.dn_m = pend_dn; o.lvl = current_level;
      if (sb.size() == 0) chk("unexpected_pulse", 32'(o), 32'd0);
      else begin
        e = sb.pop_front();
        chk("clear_pulse", 32'(o), 32'(e));
      end
    end
  endtask

  task automatic wait_door(input logic val, input int bound, output int n);
    n = 0;
    while (door_open !== val && n < bound) begin
      step();
      n++;
    end
    chk("wait_door", 32'(door_open), 32'(val));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, steps, opens;
    logic [2:0] lvl_prev;
    logic       door_prev, door_seen;

    // reset held for two cycles
    rst_n = 1'b0;
    step();
    step();
    chk("rst_level", 32'(current_level), 32'd0);
    chk("rst_dir", 32'(direction), 32'd1);
    chk("rst_moving", 32'(moving), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    chk("rst_clears", {8'h00, inactivate_in_levels, inactivate_out_up_levels,
                       inactivate_out_down_levels}, 32'd0);
    rst_n = 1'b1;
    step();

    // cabin request at the current level: one-cycle clear, three-cycle door
    act_in = 8'h01;
    push_exp(8'h01, 8'h00, 8'h00, 3'd0);
    step();
    chk("here_door", 32'(door_open), 32'd1);
    chk("here_pulse", 32'(inactivate_in_levels), 32'h01);
    step();
    chk("here_pulse_gone", 32'(inactivate_in_levels), 32'h00);
    chk("here_door2", 32'(door_open), 32'd1);
    step();
    chk("here_door3", 32'(door_open), 32'd1);
    step();
    chk("here_door_closed", 32'(door_open), 32'd0);
    chk("here_idle_moving", 32'(moving), 32'd0);

    // repeat request while open restarts the door timer
    act_in = 8'h01;
    push_exp(8'h01, 8'h00, 8'h00, 3'd0);
    step();
    step();
    act_in = 8'h01;
    push_exp(8'h01, 8'h00, 8'h00, 3'd0);
    step();
    chk("reopen_o3", 32'(door_open), 32'd1);
    step();
    chk("reopen_o4", 32'(door_open), 32'd1);
    step();
    chk("reopen_o5", 32'(door_open), 32'd1);
    step();
    chk("reopen_closed", 32'(door_open), 32'd0);

    // five-level trip up
    act_in = 8'h20;
    push_exp(8'h20, 8'h00, 8'h00, 3'd5);
    lvl_prev = current_level;
    steps = 0;
    while (door_open !== 1'b1 && steps < 100) begin
      step();
      steps++;
      if (steps == 1) chk("trip_moving", 32'(moving), 32'd1);
      if (current_level !== lvl_prev) begin
        chk("trip_level_step", 32'(current_level), 32'(lvl_prev) + 32'd1);
        lvl_prev = current_level;
      end
    end
    chk("trip_latency", 32'(steps), 32'd26);
    chk("trip_level", 32'(current_level), 32'd5);
    wait_door(1'b0, 20, n);

`ifdef ELEV_IDLE_HOME_EN
    repeat (9) step();
    chk("home_not_yet", 32'(moving), 32'd0);
    step();
    chk("home_start", 32'(moving), 32'd1);
    chk("home_dir", 32'(direction), 32'd0);
    door_seen = 1'b0;
    n = 0;
    while (!(current_level == 3'd0 && moving == 1'b0) && n < 200) begin
      step();
      n++;
      if (door_open) door_seen = 1'b1;
    end
    step();
    step();
    chk("home_level", 32'(current_level), 32'd0);
    chk("home_no_door", 32'(door_seen | door_open), 32'd0);
    chk("home_idle", 32'(moving), 32'd0);
`else
    repeat (60) step();
    chk("stay_level", 32'(current_level), 32'd5);
    chk("stay_moving", 32'(moving), 32'd0);
    chk("stay_door", 32'(door_open), 32'd0);
`endif

    // get to level 2
    act_in = 8'h04;
    push_exp(8'h04, 8'h00, 8'h00, 3'd2);
    wait_door(1'b1, 100, n);
    chk("at_level2", 32'(current_level), 32'd2);
    wait_door(1'b0, 20, n);

    // pass hall-down at 4, serve cabin 6, then reverse to 4
    act_dn = 8'h10;
    act_in = 8'h40;
    push_exp(8'h40, 8'h00, 8'h00, 3'd6);
    push_exp(8'h00, 8'h00, 8'h10, 3'd4);
    opens = 0;
    n = 0;
    door_prev = door_open;
    while (opens < 2 && n < 200) begin
      step();
      n++;
      if (door_open && !door_prev) begin
        opens++;
        if (opens == 1) begin
          chk("first_stop_level", 32'(current_level), 32'd6);
          chk("first_stop_dir", 32'(direction), 32'd1);
        end else begin
          chk("second_stop_level", 32'(current_level), 32'd4);
          chk("second_stop_dir", 32'(direction), 32'd0);
        end
      end
      door_prev = door_open;
    end
    chk("two_stops", 32'(opens), 32'd2);
    wait_door(1'b0, 20, n);

    // asynchronous reset while moving away from level 4
    act_in = 8'h01;
    step();
    step();
    step();
    chk("pre_rst_moving", 32'(moving), 32'd1);
    chk("pre_rst_level", 32'(current_level), 32'd4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_level", 32'(current_level), 32'd0);
    chk("async_moving", 32'(moving), 32'd0);
    chk("async_dir", 32'(direction), 32'd1);
    chk("async_door", 32'(door_open), 32'd0);
    chk("async_clears", {8'h00, inactivate_in_levels, inactivate_out_up_levels,
                         inactivate_out_down_levels}, 32'd0);
    act_in = 8'h00;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_level", 32'(current_level), 32'd0);
    chk("post_rst_idle", 32'(moving | door_open), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Car-motion scheduler that sits downstream of the `buttons` latch block. It consumes the latched request vectors `active_in_levels`, `active_out_up_levels` and `active_out_down_levels`. It runs a SCAN (elevator) policy, sequences the car between levels with a travel timer and a door timer, and returns one-cycle `inactivate_*` pulses that clear the requests it has served.

## Interface
- `LEVELS`, 8: number of levels; all level vectors are `LEVELS` bits wide.
- `LEVEL_W`, `$clog2(LEVELS)`: width of `current_level`.
- `TRAVEL_CYCLES`, 4: clock cycles to move one level; ≥1.
- `DOOR_CYCLES`, 3: clock cycles the door stays open; ≥1.
- `HOME_DELAY`, 16: idle cycles before the homing trip starts. Used only with `ELEV_IDLE_HOME_EN`.

- `clk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `active_in_levels` in `LEVELS`: latched cabin requests.
- `active_out_up_levels` in `LEVELS`: latched hall-up requests.
- `active_out_down_levels` in `LEVELS`: latched hall-down requests.
- `inactivate_in_levels` out `LEVELS`: one-hot, one-cycle clear pulse for cabin requests.
- `inactivate_out_up_levels` out `LEVELS`: one-hot, one-cycle clear pulse for hall-up requests.
- `inactivate_out_down_levels` out `LEVELS`: one-hot, one-cycle clear pulse for hall-down requests.
- `current_level` out `LEVEL_W`: level the car is at, or last passed.
- `direction` out 1: 1 = up, 0 = down.
- `moving` out 1: high while the travel timer runs.
- `door_open` out 1: high in OPEN.

## Operation
- Derived terms:
  - `req = in | up | down`.
  - `above` = any `req` bit at an index > `current_level`.
  - `below` = any `req` bit at an index < `current_level`.
  - `here = req[current_level]`.
- Stop condition at `current_level`:
  - Going up: `in | up | (down & ~above)`.
  - Going down: `in | down | (up & ~below)`.
- Reverse-at-turn: when a stop happens only through the opposite-direction term, flip `direction` on the same cycle as entering OPEN.
- **IDLE**: door closed, not moving.
  - `here` → OPEN.
  - Else `above`/`below` → MOVE. If both are set, keep `direction`. If only one is set, set `direction` toward it.
  - Else stay in IDLE.
- **MOVE**: `moving`=1; the timer counts `TRAVEL_CYCLES`. On expiry, `current_level` ±1 per `direction` → ARRIVE.
- **ARRIVE** (one cycle):
  - Stop condition → OPEN.
  - Else, if requests remain in `direction` → MOVE.
  - Else → IDLE.
- **OPEN**:
  - `door_open`=1 for `DOOR_CYCLES` cycles, then → IDLE.
  - On the entry cycle, pulse `inactivate_in_levels[current_level]`, plus the hall bit that matches the post-flip `direction`.
  - A request matching the served set at `current_level` that appears during OPEN: pulse its clear bit the next cycle and restart the door timer.
- `current_level` is never moved below 0 or above `LEVELS-1`; `above`/`below` cannot request it.
- `inactivate_*` are registered and all-zero except on clear cycles.

## Timing
- Reset values: `current_level`=0, `direction`=1, `moving`=0, `door_open`=0, all `inactivate_*`=0, state IDLE, timers 0.
- Reset mid-operation clears everything immediately (asynchronously), including during MOVE and OPEN; no pending pulse survives.
- Request at the current level in IDLE: registered inputs are sampled at edge N; `door_open` and the clear pulse are asserted from edge N+1.
- Per-level trip cost: `TRAVEL_CYCLES` + 1 (ARRIVE).
  - Example: a trip of k levels asserts `door_open` k·(`TRAVEL_CYCLES`+1)+1 cycles after leaving IDLE.
- Door-close → IDLE → next MOVE/OPEN: 1 cycle in IDLE.
- Inputs are assumed already synchronous, because they come from the `buttons` flops.

## Configuration
- `ELEV_IDLE_HOME_EN` defined:
  - IDLE counts consecutive cycles with `req`=0 and `current_level`≠0.
  - At `HOME_DELAY` it sets `direction`=0 and moves level by level to 0, without opening the door.
  - Any new request during the homing trip is handled normally, starting from the next ARRIVE.
  - On reaching 0 it enters IDLE.
- `ELEV_IDLE_HOME_EN` undefined: the car stays at its last level indefinitely; no idle counter is built.

## Test plan
Parameters: `LEVELS`=8, `TRAVEL_CYCLES`=4, `DOOR_CYCLES`=3.
- Reset pulse low for 2 cycles → `current_level`=0, `direction`=1, `moving`=0, `door_open`=0, all `inactivate_*`=8'h00.
- At level 0, set `active_in_levels`=8'h01 → next cycle `door_open`=1 and `inactivate_in_levels`=8'h01 for exactly 1 cycle; `door_open` lasts 3 cycles, then IDLE.
- From level 0, set `active_in_levels`=8'h20 → `moving` asserted; `current_level` steps 1..5; `door_open`=1 at 26 cycles; `inactivate_in_levels`=8'h20.
- At level 2 going up, set `active_out_down_levels`=8'h10 and `active_in_levels`=8'h40:
  - Car passes level 4 without opening.
  - Stops at 6 with `inactivate_in_levels`=8'h40.
  - Reverses, stops at 4 with only `inactivate_out_down_levels`=8'h10.
- Assert `reset` low mid-MOVE between levels 3 and 4 → asynchronously `current_level`=0 and `moving`=0; no `inactivate` pulse is emitted.
- Idle at level 5 with `HOME_DELAY`=10:
  - With `ELEV_IDLE_HOME_EN` defined: after 10 idle cycles the car descends to 0, `door_open` stays 0, and it ends in IDLE at 0.
  - With `ELEV_IDLE_HOME_EN` undefined: the car stays at 5.
